// File: rtl/hazard_ctrl.sv
// Purpose : hazard and sequencing control for a five-stage MIPS pipeline (stall, flush, bubble, forward).
// Latency : hazard/forward outputs are combinational (same cycle); state, fcnt, lost_cycles update on clk.
// Backpres: stalls PC and IF/ID on a RAW hazard; flushes IF/ID on jumps and for FLUSH_DEPTH cycles on a taken branch.
//
// Parameters: FLUSH_DEPTH (1..3) IF/ID flush cycles per taken branch; CNT_W lost-cycle counter width.
// Ports     : clk, rst (sync, active-low); ID indices/flags; EX indices/ctl; MEM/WB dest + write enable;
//             outputs pc_write, ifid_write, ifid_flush, idex_bubble, fwd_a, fwd_b, lost_cycles.
// Option    : define HAZARD_FORWARDING_EN to enable EX forwarding (only load-use then stalls).
//             Undefined: no forwarding, any dependence on a writing EX or MEM producer stalls.
module hazard_ctrl #(
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_flush,
  input  logic             id_is_branch,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic             ex_branch_taken,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regwrite,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] lost_cycles
);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  // Remaining flush cycles after the resolve cycle itself.
  localparam logic [1:0] FCNT_LOAD = 2'(FLUSH_DEPTH - 1);

  logic [0:0] state;
  logic [1:0] fcnt;

  // ID source matches against the EX destination; a nonzero id index also
  // keeps register 0 out of every comparison.
  logic ex_hit;
  logic stall_req;

  always_comb begin
    ex_hit = (id_uses_rs && (id_rs != 5'd0) && (id_rs == ex_rd)) ||
             (id_uses_rt && (id_rt != 5'd0) && (id_rt == ex_rd));
  end

`ifdef HAZARD_FORWARDING_EN
  // Only a load in EX cannot be forwarded in time.
  always_comb begin
    stall_req = ex_memread && ex_hit;
  end

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (rst) begin
      if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == ex_rs))
        fwd_a = 2'b10;
      else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == ex_rs))
        fwd_a = 2'b01;
      if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == ex_rt))
        fwd_b = 2'b10;
      else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == ex_rt))
        fwd_b = 2'b01;
    end
  end

  logic unused_nofwd_inputs;
  assign unused_nofwd_inputs = ex_regwrite;
`else
  // Without forwarding every in-flight producer ahead of WB must drain first;
  // WB itself is covered by the write-before-read register file.
  logic mem_hit;

  always_comb begin
    mem_hit = (id_uses_rs && (id_rs != 5'd0) && (id_rs == mem_rd)) ||
              (id_uses_rt && (id_rt != 5'd0) && (id_rt == mem_rd));
    stall_req = (ex_regwrite && ex_hit) || (mem_regwrite && mem_hit);
  end

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
  end

  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{ex_rs, ex_rt, wb_rd, wb_regwrite, ex_memread};
`endif

  // Priority: reset > taken branch / flush window > stall > jump flush.
  // Inside the flush window ID holds a wrong-path instruction, so its
  // stall and jump requests are ignored.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (ex_branch_taken || (state == FLUSH)) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (stall_req) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (id_flush && !id_is_branch) begin
      ifid_flush  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= RUN;
      fcnt        <= 2'd0;
      lost_cycles <= '0;
    end else begin
      if (ex_branch_taken) begin
        // A new taken branch (also one seen mid-flush) restarts the window.
        if (FLUSH_DEPTH > 1) begin
          state <= FLUSH;
          fcnt  <= FCNT_LOAD;
        end else begin
          state <= RUN;
          fcnt  <= 2'd0;
        end
      end else if (state == FLUSH) begin
        fcnt <= fcnt - 2'd1;
        if (fcnt == 2'd1)
          state <= RUN;
      end

      if ((!pc_write || ifid_flush) && (lost_cycles != {CNT_W{1'b1}}))
        lost_cycles <= lost_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic       id_uses_rs, id_uses_rt, id_flush, id_is_branch;
  logic       ex_regwrite, ex_memread, ex_branch_taken, mem_regwrite, wb_regwrite;

  logic        pc_write, ifid_write, ifid_flush, idex_bubble;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] lost_cycles;

  logic        pc_write1, ifid_write1, ifid_flush1, idex_bubble1;
  logic [1:0]  fwd_a1, fwd_b1;
  logic [1:0]  lost_cycles1;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.FLUSH_DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_flush(id_flush), .id_is_branch(id_is_branch),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b), .lost_cycles(lost_cycles)
  );

  hazard_ctrl #(.FLUSH_DEPTH(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_flush(id_flush), .id_is_branch(id_is_branch),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .pc_write(pc_write1), .ifid_write(ifid_write1), .ifid_flush(ifid_flush1),
    .idex_bubble(idex_bubble1), .fwd_a(fwd_a1), .fwd_b(fwd_b1), .lost_cycles(lost_cycles1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] id_rs, id_rt;
    logic       id_uses_rs, id_uses_rt, id_flush, id_is_branch;
    logic [4:0] ex_rs, ex_rt, ex_rd;
    logic       ex_regwrite, ex_memread;
    logic [4:0] mem_rd;
    logic       mem_regwrite;
    logic [4:0] wb_rd;
    logic       wb_regwrite;
    logic       e_pc, e_ifw, e_fl, e_bub, chk_ifw;
    logic [1:0] e_fa, e_fb;
  } vec_t;

  function automatic vec_t base();
    vec_t v;
    v.id_rs = 0; v.id_rt = 0; v.id_uses_rs = 0; v.id_uses_rt = 0;
    v.id_flush = 0; v.id_is_branch = 0;
    v.ex_rs = 0; v.ex_rt = 0; v.ex_rd = 0; v.ex_regwrite = 0; v.ex_memread = 0;
    v.mem_rd = 0; v.mem_regwrite = 0; v.wb_rd = 0; v.wb_regwrite = 0;
    v.e_pc = 1; v.e_ifw = 1; v.e_fl = 0; v.e_bub = 0; v.chk_ifw = 1;
    v.e_fa = 2'b00; v.e_fb = 2'b00;
    return v;
  endfunction

  function automatic vec_t as_stall(input vec_t vi, input bit yes);
    vec_t v;
    v = vi;
    if (yes) begin
      v.e_pc = 0; v.e_ifw = 0; v.e_bub = 1;
    end
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    id_rs = v.id_rs; id_rt = v.id_rt; id_uses_rs = v.id_uses_rs; id_uses_rt = v.id_uses_rt;
    id_flush = v.id_flush; id_is_branch = v.id_is_branch;
    ex_rs = v.ex_rs; ex_rt = v.ex_rt; ex_rd = v.ex_rd;
    ex_regwrite = v.ex_regwrite; ex_memread = v.ex_memread; ex_branch_taken = 1'b0;
    mem_rd = v.mem_rd; mem_regwrite = v.mem_regwrite; wb_rd = v.wb_rd; wb_regwrite = v.wb_regwrite;
  endtask

  task automatic idle();
    apply(base());
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic set_load_use();
    ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd2; id_rs = 5'd2; id_uses_rs = 1;
  endtask

  // Producer of $4 in EX, consumer in ID; advances the pipeline each cycle
  // the consumer is not held, and counts expected stall cycles.
  task automatic dep_seq(input bit is_load, input string tag);
    bit s1, s2;
    int exp_lost;
    do_reset();
    idle();
    exp_lost = 0;
    id_rs = 5'd4; id_uses_rs = 1; ex_rd = 5'd4; ex_regwrite = 1; ex_memread = is_load; ex_rs = 5'd9;
    s1 = is_load || !FWD;
    #1;
    chk({tag, " c1 pc_write"}, pc_write, !s1);
    chk({tag, " c1 idex_bubble"}, idex_bubble, s1);
    chk({tag, " c1 fwd_a"}, fwd_a, 2'b00);
    if (s1) exp_lost++;
    tick();
    if (s1) begin
      ex_rd = 0; ex_regwrite = 0; ex_memread = 0; ex_rs = 0;
      mem_rd = 5'd4; mem_regwrite = 1;
      s2 = !FWD;
      #1;
      chk({tag, " c2 pc_write"}, pc_write, !s2);
      chk({tag, " c2 fwd_a"}, fwd_a, 2'b00);
      if (s2) exp_lost++;
      tick();
      if (s2) begin
        mem_rd = 0; mem_regwrite = 0; wb_rd = 5'd4; wb_regwrite = 1;
        #1;
        chk({tag, " c3 pc_write"}, pc_write, 1);
        chk({tag, " c3 fwd_a"}, fwd_a, 2'b00);
        tick();
      end
    end
    idle();
    chk({tag, " lost_cycles"}, lost_cycles, exp_lost);
  endtask

  vec_t vecs[$];
  vec_t v;
  int   exp_lost;

  initial begin
    rst = 1'b0;
    idle();
    ex_branch_taken = 1;
    set_load_use();
    mem_rd = 5'd3; mem_regwrite = 1; ex_rs = 5'd3;
    @(negedge clk);

    // Reset held 3 cycles with hazards on the inputs: outputs stay forced.
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("rst c%0d pc_write", c), pc_write, 0);
      chk($sformatf("rst c%0d ifid_flush", c), ifid_flush, 1);
      if (c == 2) begin
        chk("rst ifid_write", ifid_write, 0);
        chk("rst idex_bubble", idex_bubble, 1);
        chk("rst fwd_a", fwd_a, 2'b00);
        chk("rst fwd_b", fwd_b, 2'b00);
        chk("rst lost_cycles", lost_cycles, 0);
      end
      tick();
    end
    rst = 1'b1;
    idle();
    #1;
    chk("release pc_write", pc_write, 1);
    chk("release ifid_flush", ifid_flush, 0);
    tick();
    chk("release lost_cycles", lost_cycles, 0);

    // Single-cycle vector table.
    v = base(); vecs.push_back(v);
    v = base(); v.ex_memread = 1; v.ex_regwrite = 1; v.ex_rd = 2; v.id_rs = 2; v.id_uses_rs = 1;
    vecs.push_back(as_stall(v, 1));
    v = base(); v.ex_memread = 1; v.ex_regwrite = 1; v.ex_rd = 5; v.id_rt = 5; v.id_uses_rt = 1;
    vecs.push_back(as_stall(v, 1));
    v = base(); v.ex_memread = 1; v.ex_regwrite = 1; v.ex_rd = 0; v.id_rs = 0; v.id_uses_rs = 1;
    vecs.push_back(v);
    v = base(); v.ex_memread = 1; v.ex_regwrite = 1; v.ex_rd = 2; v.id_rs = 2; v.id_uses_rs = 0;
    vecs.push_back(v);
    v = base(); v.ex_regwrite = 1; v.ex_rd = 4; v.id_rs = 4; v.id_uses_rs = 1;
    vecs.push_back(as_stall(v, !FWD));
    v = base(); v.mem_regwrite = 1; v.mem_rd = 6; v.id_rt = 6; v.id_uses_rt = 1;
    vecs.push_back(as_stall(v, !FWD));
    v = base(); v.wb_regwrite = 1; v.wb_rd = 7; v.id_rs = 7; v.id_uses_rs = 1;
    vecs.push_back(v);
    v = base(); v.mem_regwrite = 1; v.mem_rd = 3; v.wb_regwrite = 1; v.wb_rd = 3; v.ex_rs = 3;
    v.e_fa = FWD ? 2'b10 : 2'b00; vecs.push_back(v);
    v = base(); v.mem_regwrite = 1; v.mem_rd = 0; v.wb_regwrite = 1; v.wb_rd = 3; v.ex_rs = 3;
    v.e_fa = FWD ? 2'b01 : 2'b00; vecs.push_back(v);
    v = base(); v.mem_regwrite = 1; v.mem_rd = 0; v.ex_rs = 0;
    vecs.push_back(v);
    v = base(); v.mem_regwrite = 1; v.mem_rd = 9; v.ex_rs = 9; v.wb_regwrite = 1; v.wb_rd = 8; v.ex_rt = 8;
    v.e_fa = FWD ? 2'b10 : 2'b00; v.e_fb = FWD ? 2'b01 : 2'b00; vecs.push_back(v);
    v = base(); v.mem_regwrite = 0; v.mem_rd = 3; v.ex_rs = 3;
    vecs.push_back(v);
    v = base(); v.id_flush = 1; v.e_fl = 1; v.chk_ifw = 0;
    vecs.push_back(v);
    v = base(); v.id_flush = 1; v.id_is_branch = 1;
    vecs.push_back(v);
    v = base(); v.id_flush = 1; v.ex_memread = 1; v.ex_regwrite = 1; v.ex_rd = 2; v.id_rs = 2; v.id_uses_rs = 1;
    vecs.push_back(as_stall(v, 1));
    v = base(); v.ex_regwrite = 0; v.ex_rd = 4; v.id_rs = 4; v.id_uses_rs = 1;
    vecs.push_back(v);

    exp_lost = 0;
    foreach (vecs[i]) begin
      apply(vecs[i]);
      #1;
      chk($sformatf("vec%0d pc_write", i), pc_write, vecs[i].e_pc);
      if (vecs[i].chk_ifw) chk($sformatf("vec%0d ifid_write", i), ifid_write, vecs[i].e_ifw);
      chk($sformatf("vec%0d ifid_flush", i), ifid_flush, vecs[i].e_fl);
      chk($sformatf("vec%0d idex_bubble", i), idex_bubble, vecs[i].e_bub);
      chk($sformatf("vec%0d fwd_a", i), fwd_a, vecs[i].e_fa);
      chk($sformatf("vec%0d fwd_b", i), fwd_b, vecs[i].e_fb);
      if (!vecs[i].e_pc || vecs[i].e_fl) exp_lost++;
      tick();
    end
    idle();
    chk("table lost_cycles", lost_cycles, exp_lost);

    // Dependent pairs: load-use and ALU producer.
    dep_seq(1'b1, "load dep");
    dep_seq(1'b0, "alu dep");

    // Taken branch together with a load-use hazard.
    do_reset();
    idle();
    ex_branch_taken = 1; set_load_use();
    #1;
    chk("br c1 ifid_flush", ifid_flush, 1);
    chk("br c1 idex_bubble", idex_bubble, 1);
    chk("br c1 pc_write", pc_write, 1);
    chk("br d1 c1 ifid_flush", ifid_flush1, 1);
    tick();
    ex_branch_taken = 0; id_flush = 1;
    #1;
    chk("br c2 ifid_flush", ifid_flush, 1);
    chk("br c2 pc_write", pc_write, 1);
    chk("br d1 c2 ifid_flush", ifid_flush1, 0);
    chk("br d1 c2 pc_write", pc_write1, 0);
    tick();
    idle();
    #1;
    chk("br c3 ifid_flush", ifid_flush, 0);
    chk("br c3 idex_bubble", idex_bubble, 0);
    tick();
    chk("br lost_cycles", lost_cycles, 2);
    chk("br d1 lost_cycles", lost_cycles1, 2);

    // Second taken branch inside the flush window restarts it.
    do_reset();
    idle();
    ex_branch_taken = 1;
    tick();
    #1;
    chk("reload c2 ifid_flush", ifid_flush, 1);
    tick();
    ex_branch_taken = 0;
    #1;
    chk("reload c3 ifid_flush", ifid_flush, 1);
    tick();
    #1;
    chk("reload c4 ifid_flush", ifid_flush, 0);
    chk("reload lost_cycles", lost_cycles, 3);

    // Reset in the middle of a flush window aborts it.
    do_reset();
    idle();
    ex_branch_taken = 1;
    tick();
    ex_branch_taken = 0;
    rst = 0;
    #1;
    chk("rstflush pc_write", pc_write, 0);
    tick();
    rst = 1;
    #1;
    chk("rstflush after ifid_flush", ifid_flush, 0);
    chk("rstflush after pc_write", pc_write, 1);
    tick();
    chk("rstflush lost_cycles", lost_cycles, 0);

    // Counter saturation on the 2-bit instance.
    do_reset();
    idle();
    set_load_use();
    for (int c = 0; c < 5; c++) tick();
    idle();
    chk("sat lost_cycles wide", lost_cycles, 5);
    chk("sat lost_cycles narrow", lost_cycles1, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
